adv_ddr_fmt: RTL and testbench

- Parametrised next-generation ADV7511 DDR output formatter. Runs entirely in the 2x-pixel DDR clock domain, with the upstream video generator already on `clk_out`.
- Splits each DATA_W-bit pixel into two half-words on consecutive clocks and emits a pixel-rate clock marker.
- DE is selectable: passed through, generated from programmable H/V windows, or the AND of both.
- Adds sync polarity control, half-word order control and a sticky phase-error flag.

---
 rtl/adv_ddr_fmt.sv | 173 +++++++++++++++++
 tb/tb_adv_ddr_fmt.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv_ddr_fmt.sv
// adv_ddr_fmt: pixel-to-DDR half-word formatter for an ADV7511-style link.
// Runs entirely on clk_out (2x pixel rate). Every captured pixel is sent as two
// half-words on consecutive cycles. The formatter can generate DE from
// programmable H/V windows and flags pixel-strobe phase violations.
module adv_ddr_fmt #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIRST_HIGH = 0,
  parameter int unsigned DE_MODE    = 1,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned H_START    = 36,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_START    = 5,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned H_TOTAL    = 1650,
  parameter int unsigned V_TOTAL    = 750
) (
  input  logic                  clk_out,
  input  logic                  reset,
  input  logic                  pix_ce,
  input  logic                  de_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  clk_pixel_out,
  output logic                  de_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [DATA_W/2-1:0]   data_out,
  output logic                  frame_start,
  output logic                  phase_err
);

  localparam int unsigned HW    = DATA_W / 2;
  localparam int unsigned HC_W  = $clog2(H_TOTAL) + 1;
  localparam int unsigned VC_W  = $clog2(V_TOTAL) + 1;
  localparam int unsigned H_END = H_START + H_ACTIVE;
  localparam int unsigned V_END = V_START + V_ACTIVE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_reject;
  logic            w_emit_second;

  logic [HC_W-1:0] r_h_count;
  logic [HC_W-1:0] w_h_count;
  logic [VC_W-1:0] r_v_count;
  logic [VC_W-1:0] w_v_count;
  logic            r_hs;
  logic            r_vs;
  logic [HW-1:0]   r_half_b;
  logic [HW-1:0]   w_half_a;
  logic [HW-1:0]   w_half_b;
  logic            w_h_edge;
  logic            w_v_edge;
  logic            w_gen_de;
  logic            w_de_sel;
  logic            w_frame_start;

  // Phase state register
  always_ff @(posedge clk_out) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Phase next-state: a strobe in FIRST cannot start a pixel, SECOND may chain
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = pix_ce ? S_FIRST : S_IDLE;
      S_FIRST:  w_state_nxt = S_SECOND;
      S_SECOND: w_state_nxt = pix_ce ? S_FIRST : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Phase decode: accept a new pixel, reject a misphased strobe, emit 2nd half
  always_comb begin
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_emit_second = 1'b0;
    case (r_state)
      S_IDLE:   w_accept = pix_ce;
      S_FIRST: begin
        w_reject      = pix_ce;
        w_emit_second = 1'b1;
      end
      S_SECOND: w_accept = pix_ce;
      default:  w_accept = 1'b0;
    endcase
  end

  // Half-word ordering
  always_comb begin
    w_half_a = data_in[HW-1:0];
    w_half_b = data_in[DATA_W-1:HW];
    if (FIRST_HIGH != 0) begin
      w_half_a = data_in[DATA_W-1:HW];
      w_half_b = data_in[HW-1:0];
    end
  end

  // Sync edges, counter values for the incoming pixel, window and DE select
  always_comb begin
    w_h_edge  = (hsync_in == HS_POL) && (r_hs != HS_POL);
    w_v_edge  = (vsync_in == VS_POL) && (r_vs != VS_POL);
    w_h_count = (&r_h_count) ? r_h_count : r_h_count + HC_W'(1);
    if (w_h_edge) w_h_count = '0;
    w_v_count = r_v_count;
    if (w_h_edge && !(&r_v_count)) w_v_count = r_v_count + VC_W'(1);
    if (w_v_edge) w_v_count = '0;
    w_gen_de = (32'(w_h_count) >= H_START) && (32'(w_h_count) < H_END) &&
               (32'(w_v_count) >= V_START) && (32'(w_v_count) < V_END);
    w_frame_start = (32'(w_h_count) == H_START) && (32'(w_v_count) == V_START);
    case (DE_MODE)
      0:       w_de_sel = de_in;
      2:       w_de_sel = de_in & w_gen_de;
      default: w_de_sel = w_gen_de;
    endcase
  end

  // Capture registers and raster counters, advanced once per accepted pixel
  always_ff @(posedge clk_out) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_half_b  <= '0;
    end else if (w_accept) begin
      r_h_count <= w_h_count;
      r_v_count <= w_v_count;
      r_hs      <= hsync_in;
      r_vs      <= vsync_in;
      r_half_b  <= w_half_b;
    end
  end

  // Output registers: first half on accept, second half one cycle later
  always_ff @(posedge clk_out) begin
    if (reset) begin
      clk_pixel_out <= 1'b0;
      de_out        <= 1'b0;
      hsync_out     <= ~HS_POL;
      vsync_out     <= ~VS_POL;
      data_out      <= '0;
      frame_start   <= 1'b0;
      phase_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        clk_pixel_out <= 1'b1;
        data_out      <= w_half_a;
        de_out        <= w_de_sel;
        hsync_out     <= hsync_in;
        vsync_out     <= vsync_in;
        frame_start   <= w_frame_start;
      end else if (w_emit_second) begin
        clk_pixel_out <= 1'b0;
        data_out      <= r_half_b;
        frame_start   <= 1'b0;
      end
      if (w_reject) phase_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adv_ddr_fmt.sv
// tb_adv_ddr_fmt: four formatter configurations driven by one shared stimulus.
// [0] 24-bit low-first DE passthrough, [1] 36-bit high-first active-low syncs,
// [2] small raster generated DE, [3] small raster de_in AND window.
module tb_adv_ddr_fmt;

  typedef struct packed {
    int unsigned      due;
    logic [3:0][35:0] d1;
    logic [3:0][35:0] d2;
    logic [3:0]       de;
    logic [3:0]       fs;
    logic             hs;
    logic             vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic        de_in;
  logic        hs;
  logic        vs;
  logic [35:0] din;

  logic [3:0]  cp;
  logic [3:0]  de_o;
  logic [3:0]  hs_o;
  logic [3:0]  vs_o;
  logic [3:0]  fs_o;
  logic [3:0]  pe_o;
  logic [11:0] a_d;
  logic [17:0] b_d;
  logic [11:0] c_d;
  logic [11:0] d_d;
  logic [35:0] dout [4];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   sec_pending = 1'b0;
  exp_t cur;
  exp_t last_e;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dout[0] = 36'(a_d);
  assign dout[1] = 36'(b_d);
  assign dout[2] = 36'(c_d);
  assign dout[3] = 36'(d_d);

  adv_ddr_fmt #(.DATA_W(24), .FIRST_HIGH(0), .DE_MODE(0)) u_a (
    .clk_out(clk), .reset(reset), .pix_ce(pix_ce), .de_in(de_in),
    .hsync_in(hs), .vsync_in(vs), .data_in(din[23:0]),
    .clk_pixel_out(cp[0]), .de_out(de_o[0]), .hsync_out(hs_o[0]),
    .vsync_out(vs_o[0]), .data_out(a_d), .frame_start(fs_o[0]), .phase_err(pe_o[0]));

  adv_ddr_fmt #(.DATA_W(36), .FIRST_HIGH(1), .DE_MODE(0), .HS_POL(1'b0), .VS_POL(1'b0)) u_b (
    .clk_out(clk), .reset(reset), .pix_ce(pix_ce), .de_in(de_in),
    .hsync_in(hs), .vsync_in(vs), .data_in(din),
    .clk_pixel_out(cp[1]), .de_out(de_o[1]), .hsync_out(hs_o[1]),
    .vsync_out(vs_o[1]), .data_out(b_d), .frame_start(fs_o[1]), .phase_err(pe_o[1]));

  adv_ddr_fmt #(.DATA_W(24), .DE_MODE(1), .H_START(2), .H_ACTIVE(4), .V_START(1),
                .V_ACTIVE(2), .H_TOTAL(10), .V_TOTAL(5)) u_c (
    .clk_out(clk), .reset(reset), .pix_ce(pix_ce), .de_in(de_in),
    .hsync_in(hs), .vsync_in(vs), .data_in(din[23:0]),
    .clk_pixel_out(cp[2]), .de_out(de_o[2]), .hsync_out(hs_o[2]),
    .vsync_out(vs_o[2]), .data_out(c_d), .frame_start(fs_o[2]), .phase_err(pe_o[2]));

  adv_ddr_fmt #(.DATA_W(24), .DE_MODE(2), .H_START(2), .H_ACTIVE(4), .V_START(1),
                .V_ACTIVE(2), .H_TOTAL(10), .V_TOTAL(5)) u_d (
    .clk_out(clk), .reset(reset), .pix_ce(pix_ce), .de_in(de_in),
    .hsync_in(hs), .vsync_in(vs), .data_in(din[23:0]),
    .clk_pixel_out(cp[3]), .de_out(de_o[3]), .hsync_out(hs_o[3]),
    .vsync_out(vs_o[3]), .data_out(d_d), .frame_start(fs_o[3]), .phase_err(pe_o[3]));

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output pair for a pixel at raster position (x,y); x,y < 0 = off-raster
  task automatic push_px(input logic [35:0] d, input logic de, input logic h,
                         input logic v, input int x, input int y);
    exp_t e;
    logic win;
    logic fs;
    e.due   = 32'(cyc + 1);
    e.d1[0] = 36'(d[11:0]);
    e.d2[0] = 36'(d[23:12]);
    e.d1[1] = 36'(d[35:18]);
    e.d2[1] = 36'(d[17:0]);
    e.d1[2] = e.d1[0];
    e.d2[2] = e.d2[0];
    e.d1[3] = e.d1[0];
    e.d2[3] = e.d2[0];
    win     = (x >= 2) && (x < 6) && (y >= 1) && (y < 3);
    fs      = (x == 2) && (y == 1);
    e.de    = {de & win, win, de, de};
    e.fs    = {fs, fs, 1'b0, 1'b0};
    e.hs    = h;
    e.vs    = v;
    q.push_back(e);
    last_e  = e;
  endtask

  task automatic send_px(input logic [35:0] d, input logic de, input logic h,
                         input logic v, input int x, input int y);
    din    = d;
    de_in  = de;
    hs     = h;
    vs     = v;
    pix_ce = 1'b1;
    push_px(d, de, h, v, x, y);
    step();
    pix_ce = 1'b0;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cp[%0d]", tag, i), 36'(cp[i]), 36'(0));
      chk($sformatf("%s_de[%0d]", tag, i), 36'(de_o[i]), 36'(0));
      chk($sformatf("%s_data[%0d]", tag, i), dout[i], 36'(0));
      chk($sformatf("%s_fs[%0d]", tag, i), 36'(fs_o[i]), 36'(0));
      chk($sformatf("%s_pe[%0d]", tag, i), 36'(pe_o[i]), 36'(0));
      chk($sformatf("%s_hs[%0d]", tag, i), 36'(hs_o[i]), (i == 1) ? 36'(1) : 36'(0));
      chk($sformatf("%s_vs[%0d]", tag, i), 36'(vs_o[i]), (i == 1) ? 36'(1) : 36'(0));
    end
  endtask

  // Scoreboard monitor: pops one entry per FIRST cycle, checks both halves
  always @(negedge clk) begin
    if (mon_en) begin
      if (sec_pending) begin
        sec_pending = 1'b0;
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("h2_cp[%0d]", i), 36'(cp[i]), 36'(0));
          chk($sformatf("h2_data[%0d]", i), dout[i], cur.d2[i]);
          chk($sformatf("h2_de[%0d]", i), 36'(de_o[i]), 36'(cur.de[i]));
          chk($sformatf("h2_hs[%0d]", i), 36'(hs_o[i]), 36'(cur.hs));
          chk($sformatf("h2_vs[%0d]", i), 36'(vs_o[i]), 36'(cur.vs));
          chk($sformatf("h2_fs[%0d]", i), 36'(fs_o[i]), 36'(0));
        end
      end else if (cp[0] === 1'b1) begin
        chk("pixel_expected", 36'(q.size() > 0), 36'(1));
        if (q.size() > 0) begin
          cur = q.pop_front();
          sec_pending = 1'b1;
          chk("latency", 36'(cyc), 36'(cur.due));
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("h1_cp[%0d]", i), 36'(cp[i]), 36'(1));
            chk($sformatf("h1_data[%0d]", i), dout[i], cur.d1[i]);
            chk($sformatf("h1_de[%0d]", i), 36'(de_o[i]), 36'(cur.de[i]));
            chk($sformatf("h1_hs[%0d]", i), 36'(hs_o[i]), 36'(cur.hs));
            chk($sformatf("h1_vs[%0d]", i), 36'(vs_o[i]), 36'(cur.vs));
            chk($sformatf("h1_fs[%0d]", i), 36'(fs_o[i]), 36'(cur.fs[i]));
          end
        end
      end
    end
  end

  initial begin
    logic [35:0] rd;
    reset  = 1'b1;
    pix_ce = 1'b0;
    de_in  = 1'b0;
    hs     = 1'b0;
    vs     = 1'b0;
    din    = '0;
    repeat (3) step();
    @(negedge clk);
    chk_reset_vals("rst");
    step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Basic split, ordering and sync passthrough at one pixel per two cycles
    send_px(36'h000ABC123, 1'b1, 1'b0, 1'b0, -1, -1);
    send_px(36'h123456789, 1'b0, 1'b0, 1'b0, -1, -1);
    send_px(36'hFEDCBA987, 1'b1, 1'b1, 1'b1, -1, -1);
    send_px(36'h5A5A5A5A5, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (3) step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("idle_cp[%0d]", i), 36'(cp[i]), 36'(0));
      chk($sformatf("idle_hold[%0d]", i), dout[i], last_e.d2[i]);
    end

    // Back-to-back strobe: second one rejected, sticky error
    din    = 36'h111111111;
    de_in  = 1'b1;
    hs     = 1'b0;
    vs     = 1'b0;
    pix_ce = 1'b1;
    push_px(din, 1'b1, 1'b0, 1'b0, -1, -1);
    step();
    din    = 36'h222222222;
    pix_ce = 1'b1;
    step();
    pix_ce = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("perr_set[%0d]", i), 36'(pe_o[i]), 36'(1));
    repeat (4) step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("perr_idle_cp[%0d]", i), 36'(cp[i]), 36'(0));
      chk($sformatf("perr_sticky[%0d]", i), 36'(pe_o[i]), 36'(1));
      chk($sformatf("perr_hold[%0d]", i), dout[i], last_e.d2[i]);
    end

    // Reset asserted while in FIRST drops the pixel and clears the error
    step();
    mon_en = 1'b0;
    din    = 36'h000C0FFEE;
    de_in  = 1'b1;
    hs     = 1'b1;
    vs     = 1'b1;
    pix_ce = 1'b1;
    step();
    pix_ce = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("rstmid_first_cp", 36'(cp[0]), 36'(1));
    chk("rstmid_first_data", dout[0], 36'hFEE);
    step();
    reset = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    de_in = 1'b0;
    @(negedge clk);
    chk_reset_vals("rstmid");
    step();
    @(negedge clk);
    chk("rstmid_dropped_cp", 36'(cp[0]), 36'(0));
    chk("rstmid_dropped_data", dout[0], 36'(0));
    step();
    mon_en = 1'b1;
    send_px(36'h000345678, 1'b1, 1'b0, 1'b0, -1, -1);

    // Two frames of a 10x5 raster: hsync on pixel 0, vsync on line 0
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 10; x++) begin
          rd = {4'($urandom), $urandom};
          send_px(rd, (x == 3) || (x == 4), x == 0, y == 0, x, y);
        end
    din   = '0;
    hs    = 1'b0;
    vs    = 1'b0;
    de_in = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("queue_drained", 36'(q.size()), 36'(0));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("end_cp[%0d]", i), 36'(cp[i]), 36'(0));
      chk($sformatf("end_pe[%0d]", i), 36'(pe_o[i]), 36'(0));
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
